// File: rtl/hs32_sram_arbiter.sv
// hs32_sram_arbiter
// Shares one single-port 32-bit SRAM macro between the HS32 core memory port
// and the management Wishbone slave. Accesses are serialized by a 4-state FSM
// (IDLE -> ACCESS -> CAPTURE -> ACK). Simultaneous requests are granted
// round-robin. Each requester gets a one-cycle acknowledge with its read data.

module hs32_sram_arbiter #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          resetb,
   // HS32 core port
   input  logic          cpu_stb,
   input  logic          cpu_rw,
   input  logic [31:0]   cpu_addr,
   input  logic [31:0]   cpu_dtw,
   output logic          cpu_ack,
   output logic [31:0]   cpu_dtr,
   // Wishbone classic slave
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic [3:0]    wb_sel_i,
   input  logic [31:0]   wb_adr_i,
   input  logic [31:0]   wb_dat_i,
   output logic          wb_ack_o,
   output logic [31:0]   wb_dat_o,
   // SRAM macro
   output logic          sram_csb,
   output logic          sram_web,
   output logic [3:0]    sram_wmask,
   output logic [AW-1:0] sram_addr,
   output logic [31:0]   sram_din,
   input  logic [31:0]   sram_dout,
   // Status
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2,
      ACK     = 2'd3
   } state_t;

   state_t state, state_nxt;

   // CPU request latch: holds a strobe that could not be served immediately.
   logic          cpu_pend;
   logic          cpu_rw_q;
   logic [AW-1:0] cpu_addr_q;
   logic [31:0]   cpu_dtw_q;

   // last_wb: 1 when the Wishbone side won the most recent grant. It also
   // names the requester being served while the FSM is outside IDLE.
   logic          last_wb;
   logic          op_read;   // current access is a read
   logic          wb_drop;   // WB master abandoned the cycle mid-access

   logic          cpu_req;
   logic          wb_req;
   logic          start;
   logic          grant_wb_nxt;
   logic          cpu_rw_eff;
   logic [AW-1:0] cpu_addr_eff;
   logic [31:0]   cpu_dtw_eff;

   // Address bits outside the word index alias and are deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0],
                               wb_adr_i[31:AW+2], wb_adr_i[1:0]};

   assign busy = (state != IDLE);

   // Request detection, round-robin grant and the CPU operand source.
   always_comb begin
      // NOTE: every signal driven here gets a value before any branch so no
      // path leaves one unassigned, which would otherwise infer a latch.
      cpu_req      = cpu_pend | cpu_stb;
      wb_req       = wb_cyc_i & wb_stb_i;
      start        = 1'b0;
      grant_wb_nxt = 1'b0;
      cpu_rw_eff   = cpu_rw;
      cpu_addr_eff = cpu_addr[AW+1:2];
      cpu_dtw_eff  = cpu_dtw;
      if (cpu_pend) begin
         cpu_rw_eff   = cpu_rw_q;
         cpu_addr_eff = cpu_addr_q;
         cpu_dtw_eff  = cpu_dtw_q;
      end
      if (state == IDLE) begin
         start = cpu_req | wb_req;
         // WB wins when it is alone, or on a tie when the CPU went last.
         grant_wb_nxt = wb_req & (~cpu_req | ~last_wb);
      end
   end

   // Next-state logic: a fixed four-cycle walk once a request is accepted.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cpu_req || wb_req) state_nxt = ACCESS;
         ACCESS:  state_nxt = CAPTURE;
         CAPTURE: state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge resetb) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      if (!resetb) state <= IDLE;
      else         state <= state_nxt;
   end

   // CPU pending latch: set by a strobe that is not served on the spot.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         cpu_pend   <= 1'b0;
         cpu_rw_q   <= 1'b0;
         cpu_addr_q <= '0;
         cpu_dtw_q  <= '0;
      end else if (start && !grant_wb_nxt) begin
         cpu_pend <= 1'b0;
      end else if (cpu_stb && !cpu_pend) begin
         cpu_pend   <= 1'b1;
         cpu_rw_q   <= cpu_rw;
         cpu_addr_q <= cpu_addr[AW+1:2];
         cpu_dtw_q  <= cpu_dtw;
      end
   end

   // Grant bookkeeping and registered SRAM controls (csb low for ACCESS only).
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         last_wb    <= 1'b1;
         op_read    <= 1'b0;
         sram_csb   <= 1'b1;
         sram_web   <= 1'b1;
         sram_wmask <= 4'h0;
         sram_addr  <= '0;
         sram_din   <= '0;
      end else if (start) begin
         last_wb  <= grant_wb_nxt;
         sram_csb <= 1'b0;
         if (grant_wb_nxt) begin
            op_read    <= ~wb_we_i;
            sram_web   <= ~wb_we_i;
            sram_wmask <= wb_we_i ? wb_sel_i : 4'h0;
            sram_addr  <= wb_adr_i[AW+1:2];
            sram_din   <= wb_dat_i;
         end else begin
            op_read    <= ~cpu_rw_eff;
            sram_web   <= ~cpu_rw_eff;
            sram_wmask <= cpu_rw_eff ? 4'hF : 4'h0;
            sram_addr  <= cpu_addr_eff;
            sram_din   <= cpu_dtw_eff;
         end
      end else if (state == ACCESS) begin
         sram_csb   <= 1'b1;
         sram_web   <= 1'b1;
         sram_wmask <= 4'h0;
      end
   end

   // Read-data capture and one-cycle acknowledge toward the granted side.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         cpu_ack  <= 1'b0;
         wb_ack_o <= 1'b0;
         cpu_dtr  <= '0;
         wb_dat_o <= '0;
         wb_drop  <= 1'b0;
      end else begin
         cpu_ack  <= 1'b0;
         wb_ack_o <= 1'b0;
         case (state)
            IDLE: wb_drop <= 1'b0;
            ACCESS: begin
               if (last_wb && !wb_cyc_i) wb_drop <= 1'b1;
            end
            CAPTURE: begin
               if (last_wb) begin
                  // An abandoned WB cycle still finishes in the SRAM but is
                  // never acknowledged.
                  wb_ack_o <= wb_cyc_i & ~wb_drop;
                  if (op_read) wb_dat_o <= sram_dout;
               end else begin
                  cpu_ack <= 1'b1;
                  if (op_read) cpu_dtr <= sram_dout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hs32_sram_arbiter.sv
// Directed testbench for hs32_sram_arbiter with a behavioural SRAM model.

module tb_hs32_sram_arbiter;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          resetb;
   logic          cpu_stb, cpu_rw;
   logic [31:0]   cpu_addr, cpu_dtw;
   logic          cpu_ack;
   logic [31:0]   cpu_dtr;
   logic          wb_cyc_i, wb_stb_i, wb_we_i;
   logic [3:0]    wb_sel_i;
   logic [31:0]   wb_adr_i, wb_dat_i;
   logic          wb_ack_o;
   logic [31:0]   wb_dat_o;
   logic          sram_csb, sram_web;
   logic [3:0]    sram_wmask;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_din;
   logic [31:0]   sram_dout;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hs32_sram_arbiter #(.AW(AW)) dut (
      .clk(clk), .resetb(resetb),
      .cpu_stb(cpu_stb), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_dtw(cpu_dtw),
      .cpu_ack(cpu_ack), .cpu_dtr(cpu_dtr),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
      .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
      .busy(busy)
   );

   // SRAM macro model: acts on an enabled edge, read data appears after it.
   logic [31:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (!sram_csb) begin
         if (!sram_web) begin
            for (int b = 0; b < 4; b++)
               if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
         end else begin
            sram_dout <= mem[sram_addr];
         end
      end
   end

   // Protocol monitor: counts chip selects, acks and illegal ack patterns.
   int   n_csb = 0, n_csb_long = 0, n_cpu_ack = 0, n_wb_ack = 0;
   int   n_overlap = 0, n_back2back = 0;
   logic prev_ack = 1'b0, prev_csb_low = 1'b0;
   always @(negedge clk) begin
      if (resetb) begin
         if (!sram_csb) n_csb <= n_csb + 1;
         if (!sram_csb && prev_csb_low) n_csb_long <= n_csb_long + 1;
         if (cpu_ack) n_cpu_ack <= n_cpu_ack + 1;
         if (wb_ack_o) n_wb_ack <= n_wb_ack + 1;
         if (cpu_ack && wb_ack_o) n_overlap <= n_overlap + 1;
         if ((cpu_ack || wb_ack_o) && prev_ack) n_back2back <= n_back2back + 1;
         prev_ack     <= cpu_ack | wb_ack_o;
         prev_csb_low <= ~sram_csb;
      end else begin
         prev_ack     <= 1'b0;
         prev_csb_low <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_csb"},   32'(sram_csb),   32'd1);
      check({tag, "_web"},   32'(sram_web),   32'd1);
      check({tag, "_wmask"}, 32'(sram_wmask), 32'd0);
      check({tag, "_addr"},  32'(sram_addr),  32'd0);
      check({tag, "_din"},   sram_din,        32'd0);
      check({tag, "_cack"},  32'(cpu_ack),    32'd0);
      check({tag, "_wack"},  32'(wb_ack_o),   32'd0);
      check({tag, "_dtr"},   cpu_dtr,         32'd0);
      check({tag, "_wdat"},  wb_dat_o,        32'd0);
      check({tag, "_busy"},  32'(busy),       32'd0);
   endtask

   int s_csb, s_cack, s_wack;

   initial begin
      resetb = 1'b0;
      cpu_stb = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_dtw = '0;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = 4'h0;
      wb_adr_i = '0; wb_dat_i = '0;
      repeat (2) tick();
      check_reset_outputs("por");
      resetb = 1'b1;
      tick();

      // CPU write 0x0000CAFE to byte address 0x10.
      cpu_stb = 1'b1; cpu_rw = 1'b1; cpu_addr = 32'h10; cpu_dtw = 32'h0000CAFE;
      tick(); cpu_stb = 1'b0;
      check("cw_csb",   32'(sram_csb),   32'd0);
      check("cw_web",   32'(sram_web),   32'd0);
      check("cw_wmask", 32'(sram_wmask), 32'hF);
      check("cw_addr",  32'(sram_addr),  32'd4);
      check("cw_din",   sram_din,        32'h0000CAFE);
      check("cw_busy",  32'(busy),       32'd1);
      tick();
      check("cw_csb_one", 32'(sram_csb), 32'd1);
      check("cw_ack_early", 32'(cpu_ack), 32'd0);
      tick();
      check("cw_ack", 32'(cpu_ack), 32'd1);
      check("cw_dtr_hold", cpu_dtr, 32'd0);
      tick();
      check("cw_ack_pulse", 32'(cpu_ack), 32'd0);
      check("cw_idle", 32'(busy), 32'd0);

      // CPU read back byte address 0x10.
      cpu_stb = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h10; cpu_dtw = '0;
      tick(); cpu_stb = 1'b0;
      check("cr_web",   32'(sram_web),   32'd1);
      check("cr_wmask", 32'(sram_wmask), 32'd0);
      check("cr_addr",  32'(sram_addr),  32'd4);
      tick(); tick();
      check("cr_ack", 32'(cpu_ack), 32'd1);
      check("cr_dtr", cpu_dtr, 32'h0000CAFE);
      tick();

      // WB write lane 1 only, then WB read of the merged word.
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'b0010;
      wb_adr_i = 32'h10; wb_dat_i = 32'h0000AB00;
      tick();
      check("ww_wmask", 32'(sram_wmask), 32'h2);
      check("ww_web",   32'(sram_web),   32'd0);
      check("ww_addr",  32'(sram_addr),  32'd4);
      tick(); tick();
      check("ww_ack", 32'(wb_ack_o), 32'd1);
      tick();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      tick();
      check("ww_no_repeat", 32'(busy), 32'd0);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hF;
      tick(); tick(); tick();
      check("wr_ack", 32'(wb_ack_o), 32'd1);
      check("wr_dat", wb_dat_o, 32'h0000ABFE);
      tick();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      tick();

      // Two ties in a row: CPU first (last=WB), then WB (last=CPU).
      #1; s_csb = n_csb; s_cack = n_cpu_ack; s_wack = n_wb_ack;
      tick();
      cpu_stb = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h20;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h30;
      tick(); cpu_stb = 1'b0;
      check("tie1_addr", 32'(sram_addr), 32'd8);
      tick(); tick();
      check("tie1_cack", 32'(cpu_ack), 32'd1);
      check("tie1_wack", 32'(wb_ack_o), 32'd0);
      tick();
      cpu_stb = 1'b1; cpu_addr = 32'h40;
      tick(); cpu_stb = 1'b0;
      check("tie2_addr", 32'(sram_addr), 32'd12);
      tick(); tick();
      check("tie2_wack", 32'(wb_ack_o), 32'd1);
      check("tie2_cack", 32'(cpu_ack), 32'd0);
      tick();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      tick();
      check("tie2_cpu_addr", 32'(sram_addr), 32'd16);
      check("tie2_cpu_csb",  32'(sram_csb),  32'd0);
      tick(); tick();
      check("tie2_cpu_ack", 32'(cpu_ack), 32'd1);
      tick();
      #1;
      check("tie_csb_count",  32'(n_csb - s_csb),      32'd3);
      check("tie_cack_count", 32'(n_cpu_ack - s_cack), 32'd2);
      check("tie_wack_count", 32'(n_wb_ack - s_wack),  32'd1);

      // CPU pending behind a WB grant; extra strobes are ignored.
      s_csb = n_csb; s_cack = n_cpu_ack; s_wack = n_wb_ack;
      tick();
      cpu_stb = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h50;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h10;
      tick();
      check("pend_wb_first", 32'(sram_addr), 32'd4);
      cpu_addr = 32'h60;
      tick(); cpu_stb = 1'b0;
      tick();
      check("pend_wack", 32'(wb_ack_o), 32'd1);
      cpu_stb = 1'b1; cpu_addr = 32'h70;
      tick(); cpu_stb = 1'b0;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      tick();
      check("pend_cpu_addr", 32'(sram_addr), 32'd20);
      check("pend_cpu_csb",  32'(sram_csb),  32'd0);
      tick(); tick();
      check("pend_cack", 32'(cpu_ack), 32'd1);
      repeat (6) tick();
      #1;
      check("pend_csb_count",  32'(n_csb - s_csb),      32'd2);
      check("pend_cack_count", 32'(n_cpu_ack - s_cack), 32'd1);
      check("pend_wack_count", 32'(n_wb_ack - s_wack),  32'd1);

      // WB read abandoned in CAPTURE: no ack, FSM returns to IDLE.
      tick();
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h10;
      tick();
      check("drop_csb", 32'(sram_csb), 32'd0);
      tick();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      tick();
      check("drop_no_ack", 32'(wb_ack_o), 32'd0);
      check("drop_busy",   32'(busy),     32'd1);
      tick();
      check("drop_idle",   32'(busy),     32'd0);
      cpu_stb = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h10;
      tick(); cpu_stb = 1'b0;
      tick(); tick();
      check("drop_cpu_ack", 32'(cpu_ack), 32'd1);
      check("drop_cpu_dtr", cpu_dtr, 32'h0000ABFE);
      tick();

      // Asynchronous reset in the middle of ACCESS.
      cpu_stb = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h10; cpu_dtw = 32'h00001234;
      tick(); cpu_stb = 1'b0;
      check("ar_in_access", 32'(sram_csb), 32'd0);
      #2 resetb = 1'b0;
      #1;
      check_reset_outputs("ar");
      tick(); tick();
      resetb = 1'b1;
      tick();
      cpu_stb = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h10;
      tick(); cpu_stb = 1'b0;
      check("ar_next_addr", 32'(sram_addr), 32'd4);
      tick(); tick();
      check("ar_next_ack", 32'(cpu_ack), 32'd1);
      check("ar_next_dtr", cpu_dtr, 32'h0000ABFE);
      repeat (2) tick();
      #1;

      // Global protocol properties over the whole run.
      check("no_ack_overlap",   32'(n_overlap),   32'd0);
      check("no_ack_back2back", 32'(n_back2back), 32'd0);
      check("csb_single_cycle", 32'(n_csb_long),  32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hs32_sram_arbiter.md
# hs32_sram_arbiter

Shares one single-port 32-bit user SRAM macro between the HS32 core memory port and the Caravel management Wishbone slave port. Sits between `core1` and the SRAM macro inside the user project wrapper. Serializes accesses with a 4-state FSM, applies round-robin on simultaneous requests and returns read data with a one-cycle acknowledge pulse per requester.

## Interface
- `AW`, 8: SRAM word-address width; SRAM holds 2^AW 32-bit words.

- `clk`  in  1  single clock for the whole block.
- `resetb`  in  1  reset, asynchronous, active-low.
- `cpu_stb`  in  1  one-cycle request strobe from the core.
- `cpu_rw`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  32  byte address; bits [AW+1:2] used, others ignored (aliasing).
- `cpu_dtw`  in  32  write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_dtr`  out  32  read data, valid while `cpu_ack`=1.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i`  in  1  Wishbone classic controls.
- `wb_sel_i`  in  4  byte lanes.
- `wb_adr_i`  in  32  byte address, same slicing as `cpu_addr`.
- `wb_dat_i`  in  32  write data.
- `wb_ack_o`  out  1  one-cycle acknowledge.
- `wb_dat_o`  out  32  read data, valid while `wb_ack_o`=1.
- `sram_csb`  out  1  chip select, active-low.
- `sram_web`  out  1  write enable, active-low.
- `sram_wmask`  out  4  byte write mask.
- `sram_addr`  out  AW  word address.
- `sram_din`  out  32  write data to SRAM.
- `sram_dout`  in  32  SRAM read data, valid the cycle after the enabled edge.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `cpu_stb` sets `cpu_pend` and latches `cpu_rw`/`cpu_addr`/`cpu_dtw`. `cpu_stb` while `cpu_pend`=1 is ignored.
- WB request = `wb_cyc_i & wb_stb_i`, sampled in IDLE only. Master holds it until ack.
- FSM states:
  - IDLE: if any request, select grant and go to ACCESS; else stay.
  - ACCESS: registered SRAM outputs active (`sram_csb`=0). Go to CAPTURE.
  - CAPTURE: register `sram_dout` into the granted requester's data output. Go to ACK.
  - ACK: pulse the granted ack. Go to IDLE.
- Arbitration: only one requester pending → grant it. Both pending → grant the one not granted last. `last` resets to WB, so the CPU wins the first tie. `last` updates on every grant.
- CPU write: `sram_web`=0, `sram_wmask`=4'hF.
- WB write: `sram_web`=0, `sram_wmask`=`wb_sel_i`. `wb_sel_i`=0 performs no byte write but still acks.
- Reads: `sram_web`=1, `sram_wmask`=0. For writes, `cpu_dtr`/`wb_dat_o` hold their previous value.
- `cpu_pend` clears on entry to ACCESS with CPU grant. A new `cpu_stb` during service is latched for the next round.
- WB `wb_cyc_i` drops during ACCESS/CAPTURE: the SRAM op completes, `wb_ack_o` is suppressed in ACK.
- Reset (any state): FSM→IDLE, `cpu_pend`=0, `last`=WB. Outputs: `cpu_ack`=0, `wb_ack_o`=0, `cpu_dtr`=0, `wb_dat_o`=0, `sram_csb`=1, `sram_web`=1, `sram_wmask`=0, `sram_addr`=0, `sram_din`=0, `busy`=0.

## Timing
- Request sampled at edge E0 (IDLE).
- Cycle 1 (ACCESS): `sram_csb`=0; SRAM acts at E1.
- Cycle 2 (CAPTURE): `sram_dout` valid, registered at E2.
- Cycle 3 (ACK): ack=1, data valid.
- Latency: 3 cycles from sampling edge to ack. Throughput: one access per 4 cycles.
- `sram_csb`=0 for exactly one cycle per access.
- Acks are never high in two consecutive cycles. `cpu_ack` and `wb_ack_o` are never high together.
- WB master deasserts `wb_stb_i` the cycle after ack; the arbiter is in IDLE that cycle and sees no request, so there is no double service.
- Async reset takes effect immediately. Outputs reach reset values without a clock edge.

## Test plan
- Reset: assert `resetb`=0 mid-ACCESS → all outputs at reset values with no clock edge; `busy`=0, `sram_csb`=1; a later CPU request is served normally.
- CPU write 0x0000CAFE to byte addr 0x10, then CPU read 0x10 → `sram_addr`=4, `wmask`=F on the write; `cpu_dtr`=0x0000CAFE with `cpu_ack` exactly 3 cycles after `cpu_stb`.
- WB write `sel`=4'b0010, data 0x0000AB00 to 0x10, then WB read → `wb_dat_o`=0x0000ABFE.
- `cpu_stb` and WB request at the same edge, twice in a row → order CPU, WB, then on the next tie WB, CPU. One `csb` pulse per access, no overlapping acks.
- WB read issued, `wb_cyc_i` dropped in CAPTURE → no `wb_ack_o`, FSM back in IDLE after 4 cycles, next CPU request served normally.
- `cpu_stb` pulsed twice while the first request is pending in IDLE behind a WB grant → exactly one CPU access, one `cpu_ack`.
